wormhole_switch_allocator: RTL and testbench



---
 rtl/wormhole_switch_allocator_pkg.sv | 30 +++
 rtl/wormhole_switch_allocator_rr_lock_arbiter.sv | 94 +++++++++
 rtl/wormhole_switch_allocator.sv | 56 +++++
 tb/tb_wormhole_switch_allocator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wormhole_switch_allocator_pkg.sv
// Network-wide defines shared by the router blocks: port numbering and flit kinds.
package wormhole_switch_allocator_pkg;

   localparam int NET_PORT_NUM   = 5;
   localparam int NET_PORT_NUM_W = 3;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      EAST  = 3'd1,
      NORTH = 3'd2,
      WEST  = 3'd3,
      SOUTH = 3'd4
   } port_e;

   typedef enum logic [1:0] {
      FLIT_BODY     = 2'd0,
      FLIT_HEAD     = 2'd1,
      FLIT_TAIL     = 2'd2,
      FLIT_HEADTAIL = 2'd3
   } flit_type_e;

   function automatic logic flit_is_head(input flit_type_e t);
      return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
   endfunction

   function automatic logic flit_is_tail(input flit_type_e t);
      return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
   endfunction

endpackage

// File: rtl/wormhole_switch_allocator_rr_lock_arbiter.sv
// Single-output arbiter: round-robin among head flits, then locked to the winner
// until its tail flit leaves.
module wormhole_switch_allocator_rr_lock_arbiter
   import wormhole_switch_allocator_pkg::*;
#(
   parameter int PORT_NUM   = NET_PORT_NUM,
   parameter int PORT_NUM_W = NET_PORT_NUM_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PORT_NUM-1:0]   i_req,
   input  logic [PORT_NUM-1:0]   i_head,
   input  logic [PORT_NUM-1:0]   i_tail,
   input  logic                  i_ready,
   output logic [PORT_NUM-1:0]   o_grant,
   output logic                  o_valid,
   output logic [PORT_NUM_W-1:0] o_sel
);

   logic                  r_lock_valid;
   logic [PORT_NUM_W-1:0] r_lock_owner;
   logic [PORT_NUM_W-1:0] r_rr_ptr;

   logic                  w_found;
   logic [PORT_NUM_W-1:0] w_idx;
   logic [PORT_NUM_W-1:0] w_cand;
   logic                  w_tail;

   function automatic logic [PORT_NUM_W-1:0] f_next_idx(input logic [PORT_NUM_W-1:0] idx);
      if (int'(idx) >= PORT_NUM - 1) begin
         return '0;
      end
      return idx + PORT_NUM_W'(1);
   endfunction

   // Outputs are forced low while reset is held, independent of the inputs.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      if (!reset && i_ready) begin
         if (r_lock_valid) begin
            if (i_req[r_lock_owner]) begin
               w_found = 1'b1;
               w_idx   = r_lock_owner;
            end
         end else begin
            for (int k = 0; k < PORT_NUM; k++) begin
               if (int'(r_rr_ptr) + k >= PORT_NUM) begin
                  w_cand = PORT_NUM_W'(int'(r_rr_ptr) + k - PORT_NUM);
               end else begin
                  w_cand = PORT_NUM_W'(int'(r_rr_ptr) + k);
               end
               if (!w_found && i_req[w_cand] && i_head[w_cand]) begin
                  w_found = 1'b1;
                  w_idx   = w_cand;
               end
            end
         end
      end
   end

   always_comb begin
      o_grant = '0;
      if (w_found) begin
         o_grant[w_idx] = 1'b1;
      end
      o_valid = w_found;
      o_sel   = w_found ? w_idx : '0;
      w_tail  = i_tail[w_idx];
   end

   // The pointer only moves when a packet completes, so a locked packet never loses priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock_valid <= 1'b0;
         r_lock_owner <= '0;
         r_rr_ptr     <= '0;
      end else if (w_found) begin
         if (r_lock_valid) begin
            if (w_tail) begin
               r_lock_valid <= 1'b0;
               r_rr_ptr     <= f_next_idx(r_lock_owner);
            end
         end else if (w_tail) begin
            r_rr_ptr <= f_next_idx(w_idx);
         end else begin
            r_lock_valid <= 1'b1;
            r_lock_owner <= w_idx;
         end
      end
   end

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Router switch allocator: one locking round-robin arbiter per output port, with
// the per-output grants folded back onto the input ports.
module wormhole_switch_allocator
   import wormhole_switch_allocator_pkg::*;
#(
   parameter int PORT_NUM   = NET_PORT_NUM,
   parameter int PORT_NUM_W = NET_PORT_NUM_W
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [PORT_NUM-1:0]                  in_valid,
   input  logic [PORT_NUM-1:0][PORT_NUM_W-1:0]  in_next_port,
   input  logic [PORT_NUM-1:0]                  in_is_head,
   input  logic [PORT_NUM-1:0]                  in_is_tail,
   input  logic [PORT_NUM-1:0]                  out_ready,
   output logic [PORT_NUM-1:0]                  in_grant,
   output logic [PORT_NUM-1:0]                  out_valid,
   output logic [PORT_NUM-1:0][PORT_NUM_W-1:0]  out_sel
);

   logic [PORT_NUM-1:0][PORT_NUM-1:0] w_grant;

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
      logic [PORT_NUM-1:0] w_req;

      // Route results outside 0..PORT_NUM-1 never equal any o and so are never requested.
      always_comb begin
         for (int i = 0; i < PORT_NUM; i++) begin
            w_req[i] = in_valid[i] && (in_next_port[i] == PORT_NUM_W'(o));
         end
      end

      wormhole_switch_allocator_rr_lock_arbiter #(
         .PORT_NUM   (PORT_NUM),
         .PORT_NUM_W (PORT_NUM_W)
      ) u_arb (
         .clk     (clk),
         .reset   (reset),
         .i_req   (w_req),
         .i_head  (in_is_head),
         .i_tail  (in_is_tail),
         .i_ready (out_ready[o]),
         .o_grant (w_grant[o]),
         .o_valid (out_valid[o]),
         .o_sel   (out_sel[o])
      );
   end

   always_comb begin
      in_grant = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         in_grant = in_grant | w_grant[o];
      end
   end

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Bench for the switch allocator: directed test-plan scenarios followed by random
// traffic, all scored against a per-output packet-level reference model.
module tb_wormhole_switch_allocator;
   import wormhole_switch_allocator_pkg::*;

   localparam int P = 5;
   localparam int W = 3;

   logic               clk;
   logic               rst;
   logic [P-1:0]       iv;
   logic [P-1:0][W-1:0] np;
   logic [P-1:0]       hd;
   logic [P-1:0]       tl;
   logic [P-1:0]       rdy;
   logic [P-1:0]       in_grant;
   logic [P-1:0]       out_valid;
   logic [P-1:0][W-1:0] out_sel;

   int errors = 0;
   int checks = 0;

   // Reference state: which input owns each output and who is next in line.
   int m_lock [P];
   int m_own  [P];
   int m_ptr  [P];
   int n_lock [P];
   int n_own  [P];
   int n_ptr  [P];
   logic [P-1:0]        exp_g;
   logic [P-1:0]        exp_ov;
   logic [P-1:0][W-1:0] exp_os;

   wormhole_switch_allocator #(.PORT_NUM(P), .PORT_NUM_W(W)) dut (
      .clk          (clk),
      .reset        (rst),
      .in_valid     (iv),
      .in_next_port (np),
      .in_is_head   (hd),
      .in_is_tail   (tl),
      .out_ready    (rdy),
      .in_grant     (in_grant),
      .out_valid    (out_valid),
      .out_sel      (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < P; o++) begin
         m_lock[o] = 0;
         m_own[o]  = 0;
         m_ptr[o]  = 0;
      end
   endtask

   task automatic clr_in();
      iv = '0; np = '0; hd = '0; tl = '0;
   endtask

   task automatic set_in(input int i, input int port, input flit_type_e t);
      iv[i] = 1'b1;
      np[i] = W'(port);
      hd[i] = flit_is_head(t);
      tl[i] = flit_is_tail(t);
   endtask

   // Settle, predict the cycle's transfers from the packet rules, and compare.
   task automatic eval();
      int g, bestd, d;
      #1;
      exp_g = '0; exp_ov = '0; exp_os = '0;
      for (int o = 0; o < P; o++) begin
         n_lock[o] = m_lock[o];
         n_own[o]  = m_own[o];
         n_ptr[o]  = m_ptr[o];
         g = -1;
         if (!rst && rdy[o]) begin
            if (m_lock[o] != 0) begin
               if (iv[m_own[o]] && int'(np[m_own[o]]) == o) g = m_own[o];
            end else begin
               bestd = P;
               for (int i = 0; i < P; i++) begin
                  if (iv[i] && hd[i] && int'(np[i]) == o) begin
                     d = (i - m_ptr[o] + P) % P;
                     if (d < bestd) begin
                        bestd = d;
                        g = i;
                     end
                  end
               end
            end
         end
         if (g >= 0) begin
            exp_g[g]  = 1'b1;
            exp_ov[o] = 1'b1;
            exp_os[o] = W'(g);
            if (m_lock[o] != 0) begin
               if (tl[g]) begin
                  n_lock[o] = 0;
                  n_ptr[o]  = (g + 1) % P;
               end
            end else if (tl[g]) begin
               n_ptr[o] = (g + 1) % P;
            end else begin
               n_lock[o] = 1;
               n_own[o]  = g;
            end
         end
      end
      chk("in_grant", 32'(in_grant), 32'(exp_g));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_sel", 32'(out_sel), 32'(exp_os));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int o = 0; o < P; o++) begin
            m_lock[o] = n_lock[o];
            m_own[o]  = n_own[o];
            m_ptr[o]  = n_ptr[o];
         end
      end
      #1;
   endtask

   initial begin
      int rr_exp [6];
      rr_exp = '{1, 4, 16, 1, 4, 16};
      rst = 1'b1;
      rdy = '1;
      clr_in();
      model_reset();
      @(posedge clk);
      #1;
      eval();
      // Requests present during reset must not be granted.
      set_in(1, EAST, FLIT_HEADTAIL);
      eval();
      chk("reset_grant", 32'(in_grant), 0);
      chk("reset_valid", 32'(out_valid), 0);
      tick();
      rst = 1'b0;
      clr_in();

      // Single-flit packet, then pointer moved past input 1.
      set_in(1, EAST, FLIT_HEADTAIL);
      eval();
      chk("single_grant", 32'(in_grant), 2);
      chk("single_oval", 32'(out_valid[EAST]), 1);
      chk("single_sel", 32'(out_sel[EAST]), 1);
      tick();
      set_in(2, EAST, FLIT_HEADTAIL);
      eval();
      chk("single_ptr_next", 32'(in_grant), 4);
      tick();
      clr_in();

      // Wormhole lock on SOUTH: input 3 waits behind input 0's packet.
      set_in(0, SOUTH, FLIT_HEAD);
      eval(); chk("worm_head", 32'(in_grant), 1); tick();
      set_in(0, SOUTH, FLIT_BODY); set_in(3, SOUTH, FLIT_HEAD);
      eval(); chk("worm_body1", 32'(in_grant), 1); tick();
      eval(); chk("worm_body2", 32'(in_grant), 1); tick();
      set_in(0, SOUTH, FLIT_TAIL);
      eval(); chk("worm_tail", 32'(in_grant), 1); tick();
      iv[0] = 1'b0;
      eval();
      chk("worm_waiter", 32'(in_grant), 8);
      chk("worm_waiter_sel", 32'(out_sel[SOUTH]), 3);
      tick();
      set_in(3, SOUTH, FLIT_TAIL);
      eval(); tick();
      clr_in();

      // Round-robin among three single-flit streams to WEST.
      for (int c = 0; c < 6; c++) begin
         set_in(0, WEST, FLIT_HEADTAIL);
         set_in(2, WEST, FLIT_HEADTAIL);
         set_in(4, WEST, FLIT_HEADTAIL);
         eval();
         chk("rr_order", 32'(in_grant), 32'(rr_exp[c]));
         tick();
      end
      clr_in();

      // Backpressure on NORTH while mid-packet; a competing head must not steal it.
      set_in(1, NORTH, FLIT_HEAD);
      eval(); tick();
      set_in(1, NORTH, FLIT_BODY);
      set_in(0, NORTH, FLIT_HEAD);
      rdy[NORTH] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         eval();
         chk("bp_no_valid", 32'(out_valid[NORTH]), 0);
         chk("bp_no_grant", 32'(in_grant), 0);
         tick();
      end
      rdy[NORTH] = 1'b1;
      eval(); chk("bp_resume", 32'(in_grant), 2); tick();
      set_in(1, NORTH, FLIT_TAIL);
      eval(); tick();
      clr_in();

      // Two outputs granting different inputs in the same cycle.
      set_in(1, EAST, FLIT_HEAD);
      set_in(2, WEST, FLIT_HEAD);
      eval();
      chk("par_grant", 32'(in_grant), 6);
      chk("par_sel_e", 32'(out_sel[EAST]), 1);
      chk("par_sel_w", 32'(out_sel[WEST]), 2);
      tick();
      set_in(1, EAST, FLIT_TAIL);
      set_in(2, WEST, FLIT_TAIL);
      eval(); tick();
      clr_in();

      // Reset while EAST is locked to input 4.
      set_in(4, EAST, FLIT_HEAD);
      eval(); tick();
      set_in(4, EAST, FLIT_BODY);
      eval();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_mid_grant", 32'(in_grant), 0);
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_sel", 32'(out_sel), 0);
      eval(); tick();
      rst = 1'b0;
      set_in(0, EAST, FLIT_HEAD);
      eval();
      chk("post_rst_grant", 32'(in_grant), 1);
      chk("post_rst_oval", 32'(out_valid[EAST]), 1);
      tick();
      set_in(0, EAST, FLIT_TAIL);
      eval(); tick();
      clr_in();

      // Random traffic, including unroutable ports and protocol-violating flits.
      for (int c = 0; c < 400; c++) begin
         rdy = ($urandom_range(0, 3) == 0) ? P'($urandom) : '1;
         for (int i = 0; i < P; i++) begin
            iv[i] = ($urandom_range(0, 3) != 0);
            np[i] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(5, 7)) : W'($urandom_range(0, 4));
            hd[i] = ($urandom_range(0, 1) != 0);
            tl[i] = ($urandom_range(0, 2) == 0);
         end
         eval();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
